// File: rtl/shmcp_pkg.sv
// Shared definitions for the processor-side host tooling.
// Holds the program-loader state encoding, the instruction width and the
// processor mode encoding driven on the processor's `state` input.
package shmcp_pkg;

    localparam int INSTR_W = 8;

    // Processor mode as seen on its `state` input.
    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loader_state_e;

endpackage : shmcp_pkg

// File: rtl/prog_buf.sv
// Program buffer: DEPTH x INSTR_W register file, not reset.
// Ports:
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (asynchronous read)
//   rdata_o  - read data
module prog_buf #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = 8,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Synchronous write port; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : prog_buf

// File: rtl/prog_loader.sv
// Program loader: buffers a host byte stream, then replays it into the
// processor's instruction-load interface and holds the processor in run mode.
// Optional checksum gate: define PROG_LOADER_CHECKSUM_EN to refuse `start`
// when the XOR of buffered bytes differs from `chk` (reported on `err`).
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   in_valid/in_data  - host byte stream, in_ready is the accept signal
//   start/stop/clear  - sequence control
//   load/instr/state  - processor load enable, instruction, mode
//   busy/done         - LOAD or RUN active / one-cycle pulse on entering RUN
//   count             - number of buffered instructions
//   err/chk           - checksum failure flag / expected checksum
module prog_loader #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = shmcp_pkg::INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_data,
    output logic                     in_ready,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    output logic                     load,
    output logic [INSTR_W-1:0]       instr,
    output logic                     state,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    input  logic [INSTR_W-1:0]       chk
);

    import shmcp_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    loader_state_e      fsm_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      rd_ptr_q;   // index of the next instruction to issue
    logic               load_q;
    logic [INSTR_W-1:0] instr_q;
    logic               mode_q;
    logic               busy_q;
    logic               done_q;

    logic               full_s;
    logic               in_ready_s;
    logic               we_s;
    logic               chk_ok_s;
    logic               start_req_s;
    logic               start_go_s;
    logic [AW-1:0]      raddr_s;
    logic [INSTR_W-1:0] rdata_s;

    assign full_s      = (count_q == CW'(DEPTH));
    assign in_ready_s  = (fsm_q == IDLE) && !full_s && !start && !clear;
    assign we_s        = in_valid && in_ready_s;
    // clear takes precedence over start in the same cycle
    assign start_req_s = (fsm_q == IDLE) && start && !clear && (count_q != {CW{1'b0}});
    assign start_go_s  = start_req_s && chk_ok_s;

    // Read address: entry 0 while launching from IDLE, rd_ptr while loading.
    always_comb begin
        raddr_s = {AW{1'b0}};
        if (fsm_q == LOAD) begin
            raddr_s = rd_ptr_q[AW-1:0];
        end else begin
            raddr_s = {AW{1'b0}};
        end
    end

    prog_buf #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .AW      (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (raddr_s),
        .rdata_o (rdata_s)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] xor_q;
    logic               err_q;

    assign chk_ok_s = (xor_q == chk);

    // Running XOR of accepted bytes and the checksum failure flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xor_q <= {INSTR_W{1'b0}};
            err_q <= 1'b0;
        end else if (fsm_q == IDLE) begin
            if (clear) begin
                xor_q <= {INSTR_W{1'b0}};
                err_q <= 1'b0;
            end else if (we_s) begin
                xor_q <= xor_q ^ in_data;
                err_q <= 1'b0;
            end else if (start_req_s) begin
                err_q <= !chk_ok_s;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_chk_s;

    assign chk_ok_s     = 1'b1;
    assign unused_chk_s = ^chk;
    assign err          = 1'b0;
`endif

    // Loader FSM with all processor-facing outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q    <= IDLE;
            count_q  <= {CW{1'b0}};
            rd_ptr_q <= {CW{1'b0}};
            load_q   <= 1'b0;
            instr_q  <= {INSTR_W{1'b0}};
            mode_q   <= MODE_LOAD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (clear) begin
                        count_q <= {CW{1'b0}};
                    end else if (we_s) begin
                        count_q <= count_q + CW'(1);
                    end else if (start_go_s) begin
                        // first instruction goes out in the cycle after start
                        fsm_q    <= LOAD;
                        load_q   <= 1'b1;
                        instr_q  <= rdata_s;
                        rd_ptr_q <= CW'(1);
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        fsm_q    <= IDLE;
                        load_q   <= 1'b0;
                        instr_q  <= {INSTR_W{1'b0}};
                        rd_ptr_q <= {CW{1'b0}};
                        busy_q   <= 1'b0;
                    end else if (rd_ptr_q == count_q) begin
                        // last instruction was issued in the current cycle
                        fsm_q    <= RUN;
                        load_q   <= 1'b0;
                        instr_q  <= {INSTR_W{1'b0}};
                        rd_ptr_q <= {CW{1'b0}};
                        mode_q   <= MODE_RUN;
                        done_q   <= 1'b1;
                    end else begin
                        instr_q  <= rdata_s;
                        rd_ptr_q <= rd_ptr_q + CW'(1);
                    end
                end
                RUN: begin
                    if (stop) begin
                        fsm_q  <= IDLE;
                        mode_q <= MODE_LOAD;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    fsm_q    <= IDLE;
                    rd_ptr_q <= {CW{1'b0}};
                    load_q   <= 1'b0;
                    instr_q  <= {INSTR_W{1'b0}};
                    mode_q   <= MODE_LOAD;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign load     = load_q;
    assign instr    = instr_q;
    assign state    = mode_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic [7:0] instr;
    logic       state;
    logic       busy;
    logic       done;
    logic [4:0] count;
    logic       err;
    logic [7:0] chk;

    int checks;
    int failures;

    prog_loader #(.DEPTH(16), .INSTR_W(8)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .instr    (instr),
        .state    (state),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .err      (err),
        .chk      (chk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       st;
        logic       sp;
        logic       cl;
        logic [7:0] ck;
        logic       e_load;
        logic [7:0] e_instr;
        logic       e_state;
        logic       e_busy;
        logic       e_done;
        logic [4:0] e_count;
        logic       e_ready;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic st, input logic sp,
                       input logic cl, input logic [7:0] ck, input logic e_load,
                       input logic [7:0] e_instr, input logic e_state, input logic e_busy,
                       input logic e_done, input logic [4:0] e_count, input logic e_ready);
        vec_t r;
        r.v = v; r.d = d; r.st = st; r.sp = sp; r.cl = cl; r.ck = ck;
        r.e_load = e_load; r.e_instr = e_instr; r.e_state = e_state; r.e_busy = e_busy;
        r.e_done = e_done; r.e_count = e_count; r.e_ready = e_ready;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic st,
                         input logic sp, input logic cl);
        @(negedge clk);
        in_valid = v; in_data = d; start = st; stop = sp; clear = cl;
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_load"},  {31'd0, load},  32'd0);
        check({tag, "_instr"}, {24'd0, instr}, 32'd0);
        check({tag, "_state"}, {31'd0, state}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_done"},  {31'd0, done},  32'd0);
        check({tag, "_err"},   {31'd0, err},   32'd0);
        check({tag, "_count"}, {27'd0, count}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int acc;
        int nload;
        bit found;
        checks = 0;
        failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        stop = 1'b0; clear = 1'b0; chk = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // basic replay 12/34/56 (xor 70)
        add(1,8'h12,0,0,0,8'h00, 0,8'h00,0,0,0,5'd0,1);
        add(1,8'h34,0,0,0,8'h00, 0,8'h00,0,0,0,5'd1,1);
        add(1,8'h56,0,0,0,8'h00, 0,8'h00,0,0,0,5'd2,1);
        add(0,8'h00,1,0,0,8'h70, 0,8'h00,0,0,0,5'd3,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'h12,0,1,0,5'd3,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'h34,0,1,0,5'd3,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'h56,0,1,0,5'd3,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,1,1,1,5'd3,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,1,1,0,5'd3,0);
        add(0,8'h00,0,1,0,8'h00, 0,8'h00,1,1,0,5'd3,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,0,0,0,5'd3,1);
        // clear wins over in_valid, then start on empty buffer
        add(1,8'hAA,0,0,1,8'h00, 0,8'h00,0,0,0,5'd3,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,0,0,0,5'd0,1);
        add(0,8'h00,1,0,0,8'h00, 0,8'h00,0,0,0,5'd0,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,0,0,0,5'd0,1);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,0,0,0,5'd0,1);
        // abort in 2nd LOAD cycle, then full replay (xor 04)
        add(1,8'hA1,0,0,0,8'h00, 0,8'h00,0,0,0,5'd0,1);
        add(1,8'hB2,0,0,0,8'h00, 0,8'h00,0,0,0,5'd1,1);
        add(1,8'hC3,0,0,0,8'h00, 0,8'h00,0,0,0,5'd2,1);
        add(1,8'hD4,0,0,0,8'h00, 0,8'h00,0,0,0,5'd3,1);
        add(0,8'h00,1,0,0,8'h04, 0,8'h00,0,0,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'hA1,0,1,0,5'd4,0);
        add(0,8'h00,0,1,0,8'h00, 1,8'hB2,0,1,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,0,0,0,5'd4,1);
        add(0,8'h00,1,0,0,8'h04, 0,8'h00,0,0,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'hA1,0,1,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'hB2,0,1,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'hC3,0,1,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 1,8'hD4,0,1,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,1,1,1,5'd4,0);
        add(0,8'h00,0,1,0,8'h00, 0,8'h00,1,1,0,5'd4,0);
        add(0,8'h00,0,0,0,8'h00, 0,8'h00,0,0,0,5'd4,1);

        for (int i = 0; i < tbl.size(); i++) begin
            chk = tbl[i].ck;
            drive(tbl[i].v, tbl[i].d, tbl[i].st, tbl[i].sp, tbl[i].cl);
            check($sformatf("vec%0d_load", i),  {31'd0, load},  {31'd0, tbl[i].e_load});
            check($sformatf("vec%0d_instr", i), {24'd0, instr}, {24'd0, tbl[i].e_instr});
            check($sformatf("vec%0d_state", i), {31'd0, state}, {31'd0, tbl[i].e_state});
            check($sformatf("vec%0d_busy", i),  {31'd0, busy},  {31'd0, tbl[i].e_busy});
            check($sformatf("vec%0d_done", i),  {31'd0, done},  {31'd0, tbl[i].e_done});
            check($sformatf("vec%0d_count", i), {27'd0, count}, {27'd0, tbl[i].e_count});
            check($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ready});
            check($sformatf("vec%0d_err", i),   {31'd0, err},   32'd0);
        end
        chk = 8'h00;

        // reset while in RUN (program 01 02 03, xor 00)
        drive(0, 8'h00, 0, 0, 1);
        drive(1, 8'h01, 0, 0, 0);
        drive(1, 8'h02, 0, 0, 0);
        drive(1, 8'h03, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(0, 8'h00, 0, 0, 0);
            if (state) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_run_reached", {31'd0, found}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_zero("rst_release");

        // full buffer: 20 bytes offered, 16 accepted
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'h40 + 8'(i), 0, 0, 0);
            if (in_ready) acc++;
        end
        drive(0, 8'h00, 0, 0, 0);
        check("full_accepted", acc, 32'd16);
        check("full_count", {27'd0, count}, 32'd16);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        drive(0, 8'h00, 1, 0, 0);
        nload = 0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            drive(0, 8'h00, 0, 0, 0);
            if (state) begin
                found = 1'b1;
                break;
            end
            if (load) begin
                check($sformatf("full_instr%0d", nload), {24'd0, instr}, 32'h40 + nload);
                nload++;
            end
        end
        check("full_run_reached", {31'd0, found}, 32'd1);
        check("full_nload", nload, 32'd16);
        drive(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 0);
        check("full_stopped", {31'd0, busy}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // checksum mismatch blocks start, matching checksum proceeds
        drive(0, 8'h00, 0, 0, 1);
        drive(1, 8'h0F, 0, 0, 0);
        drive(1, 8'hF0, 0, 0, 0);
        chk = 8'h00;
        drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        check("cks_err_set", {31'd0, err}, 32'd1);
        check("cks_busy_low", {31'd0, busy}, 32'd0);
        check("cks_load_low", {31'd0, load}, 32'd0);
        chk = 8'hFF;
        drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        check("cks_ok_err", {31'd0, err}, 32'd0);
        check("cks_ok_load", {31'd0, load}, 32'd1);
        check("cks_ok_instr", {24'd0, instr}, 32'h0F);
        drive(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_loader

// File: doc/prog_loader.md
# prog_loader

Program loader that drives the processor's instruction-load interface (`load`, `instr`, `state`) from the host side. It buffers a program received over a valid/ready byte stream. On `start` it replays the program into the processor one instruction per cycle in load mode, then holds the processor in run mode until stopped. It sits beside the processor top level, between the host/debug link and the processor's `load`/`instr`/`state` inputs.

## Interface
- `DEPTH`, 16: program buffer entries, power of two, 2..256
- `INSTR_W`, 8: instruction width; must match the processor instruction input
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  host byte valid
- `in_data`  in  INSTR_W  host instruction byte
- `in_ready`  out  1  loader accepts a byte this cycle
- `start`  in  1  begin load/run sequence (level sampled each cycle)
- `stop`  in  1  abort load or leave run, back to IDLE
- `clear`  in  1  empty the buffer (IDLE only)
- `load`  out  1  processor instruction-load enable
- `instr`  out  INSTR_W  instruction presented to processor
- `state`  out  1  processor mode: 0 = load/halt, 1 = run
- `busy`  out  1  high in LOAD or RUN
- `done`  out  1  one-cycle pulse on entry to RUN
- `count`  out  $clog2(DEPTH)+1  number of buffered instructions
- `err`  out  1  checksum failure flag (see Configuration)
- `chk`  in  INSTR_W  expected checksum (see Configuration)

## Operation
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - `in_ready = !full && !start && !clear`.
  - A handshake (`in_valid && in_ready`) writes `in_data` to `buf[count]` and increments `count`.
  - `clear` sets `count` to 0. It wins over `in_valid`; that byte is not accepted.
  - `start` with `count == 0` is ignored.
  - `start` with `count > 0` moves to LOAD, with `rd_ptr = 0`.
- LOAD:
  - Each cycle: `load = 1`, `instr = buf[rd_ptr]`, `rd_ptr++`.
  - After the instruction at `rd_ptr == count-1` has been issued, move to RUN.
  - `in_ready = 0`.
- RUN:
  - `state = 1`, `load = 0`, `instr = 0`.
  - Stays in RUN until `stop`.
- `stop` in LOAD or RUN returns to IDLE the next cycle. `load` and `state` drop to 0. Buffer and `count` are retained, so a later `start` replays the same program.
- `start` and `clear` outside IDLE are ignored. `stop` in IDLE is ignored.
- `stop` has priority over the normal LOAD→RUN transition in the same cycle.
- When full (`count == DEPTH`), `in_ready = 0` and `in_valid` bytes are not accepted. No overflow, no wrap.
- Reset, at any time including mid-LOAD or mid-RUN:
  - State goes to IDLE; `count`, `rd_ptr`, `load`, `state`, `done`, `err` go to 0, and `instr` = 0.
  - Buffer contents are don't-care.

## Timing
- `load`, `instr`, `state`, `done`, `busy` are registered outputs. `in_ready` is combinational from state, `count`, `start`, `clear`.
- `start` sampled high at edge N (IDLE, `count = C`):
  - `load = 1` with `instr = buf[0]` during cycle N+1, through `buf[C-1]` during cycle N+C.
  - `state = 1` and `done = 1` during cycle N+C+1.
- Load throughput: one instruction per cycle, no gaps; total latency `start`→run is C+1 cycles.
- `stop` sampled at edge M: `load = 0`, `state = 0`, `busy = 0` from cycle M+1.
- A byte accepted at edge K is visible in `count` from cycle K+1.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - A running XOR of accepted bytes is kept; it is cleared with `count`.
  - On `start` with `count > 0`, if XOR ≠ `chk`, the FSM stays in IDLE and `err` is set to 1.
  - `err` is cleared by the next accepted byte, by `clear`, or by a successful `start`.
- Not defined: `chk` is ignored, `err` is tied to 0, and no XOR register is built.

## Structure
- Shared package `shmcp_pkg` holds:
  - The loader state enum (IDLE, LOAD, RUN).
  - `INSTR_W = 8` and the processor mode constants `MODE_LOAD = 0`, `MODE_RUN = 1`.
- One sub-module, `prog_buf`: DEPTH×INSTR_W register file with one synchronous write port and one asynchronous read port. It is not reset.

## Test plan
- Reset mid-RUN:
  - Stimulus: 3-byte program, `start`, then `rst` low for one cycle while `state = 1`.
  - Required: all outputs 0, `count = 0`, `in_ready = 1`.
- Basic replay:
  - Stimulus: send 0x12, 0x34, 0x56, then pulse `start`.
  - Required: `load = 1` for exactly 3 cycles with `instr` 0x12, 0x34, 0x56; then `state = 1` and a one-cycle `done`, 4 cycles after `start`.
- Full buffer:
  - Stimulus: with `DEPTH = 16`, hold `in_valid` for 20 bytes.
  - Required: 16 accepted, `count = 16`, `in_ready = 0` afterwards; replay issues exactly 16 instructions.
- Abort and replay:
  - Stimulus: `stop` during the 2nd LOAD cycle of a 4-byte program.
  - Required: `load = 0` next cycle, `count` still 4; a second `start` replays all 4 from `buf[0]`.
- Simultaneous events and empty buffer:
  - Stimulus: `clear` with `in_valid` (0xAA) in the same cycle; later, `start` while `count = 0`.
  - Required: byte not accepted, `count = 0`; `start` ignored, `busy` stays 0.
- Checksum (macro defined):
  - Stimulus: send 0x0F, 0xF0 with `chk = 0x00`, then `start`.
  - Required: `err = 1`, stays IDLE. With `chk = 0xFF` the load proceeds normally.
